tm_cpu_timing_ctrl: RTL and testbench

// - Parametrised per-thread CPU pipeline timing model. Consumes FM->TM tokens (tm_cpu_ctrl_token_type), returns TM->FM tokens (tm2cpu_token_type).
// - Gates each thread's run bit with a per-class target-latency stall counter; keeps per-thread retired-insn counters and a global target-cycle count.
// - Sits between the functional-model CPU pipeline (regacc stage) and the DMA debug controller (dma_tm_ctrl_type).

---
 rtl/tm_cpu_timing_ctrl_pkg.sv | 46 ++++
 rtl/tm_cpu_timing_ctrl_classify.sv | 30 +++
 rtl/tm_cpu_timing_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tm_cpu_timing_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_cpu_timing_ctrl_pkg.sv
// rtl/tm_cpu_timing_ctrl_pkg.sv - shared types and widths for the CPU pipeline timing model
package tm_cpu_timing_ctrl_pkg;

    localparam int NTHREAD      = 64;
    localparam int NTHREADIDMSB = $clog2(NTHREAD) - 1;
    localparam int STALL_W      = 4;
    localparam int CNT_W        = 32;

    typedef enum logic [1:0] {tm_ALU, tm_MUL, tm_DIV, tm_LDST} tm_inst_class_type;

    typedef enum logic [1:0] {tm_CLEAR, tm_IDLE, tm_RUN} tm_ctrl_state_type;

    typedef enum logic [2:0] {
        tm_dbg_nop,
        tm_dbg_start,
        tm_dbg_stop,
        tm_dbg_select_start,
        tm_dbg_select_stop
    } tm_dbg_ctrl_type;

    typedef struct packed {
        logic [STALL_W-1:0] stall;
    } tm_thread_state_type;

    typedef struct packed {
        logic                  valid;
        logic [NTHREADIDMSB:0] tid;
        logic                  retired;
        logic                  replay;
        logic [31:0]           inst;
    } tm_cpu_ctrl_token_type;

    typedef struct packed {
        logic                  valid;
        logic                  run;
        logic [NTHREADIDMSB:0] tid;
        logic                  running;
    } tm2cpu_token_type;

    typedef struct packed {
        logic [NTHREADIDMSB:0] threads_active;
        logic [NTHREADIDMSB:0] threads_total;
        tm_dbg_ctrl_type       tm_dbg_ctrl;
    } dma_tm_ctrl_type;

endpackage

// File: rtl/tm_cpu_timing_ctrl_classify.sv
// rtl/tm_cpu_timing_ctrl_classify.sv - SPARC instruction to latency class decode
module tm_inst_classify
    import tm_cpu_timing_ctrl_pkg::*;
(
    input  logic [31:0]       inst,
    output tm_inst_class_type inst_class
);

    logic [1:0] op;
    logic [5:0] op3;
    logic       unused_bits;

    assign op          = inst[31:30];
    assign op3         = inst[24:19];
    assign unused_bits = ^{inst[29:25], inst[18:0]};

    always_comb begin
        inst_class = tm_ALU;
        if (op == 2'b11) begin
            inst_class = tm_LDST;
        end else if (op == 2'b10) begin
            case (op3)
                6'h0A, 6'h0B, 6'h1A, 6'h1B: inst_class = tm_MUL;
                6'h0E, 6'h0F, 6'h1E, 6'h1F: inst_class = tm_DIV;
                default:                    inst_class = tm_ALU;
            endcase
        end
    end

endmodule

// File: rtl/tm_cpu_timing_ctrl.sv
// rtl/tm_cpu_timing_ctrl.sv - per-thread target-latency gating of FM tokens with retire counters
module tm_cpu_timing_ctrl
    import tm_cpu_timing_ctrl_pkg::*;
#(
    parameter int LAT_ALU  = 0,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 11,
    parameter int LAT_LDST = 1
) (
    input  logic                  gclk,
    input  logic                  rst,
    input  tm_cpu_ctrl_token_type fm_tok,
    input  dma_tm_ctrl_type       dma_ctrl,
    output tm2cpu_token_type      tm_tok,
    input  logic [NTHREADIDMSB:0] cnt_rd_tid,
    output logic [CNT_W-1:0]      cnt_rd_data,
    output logic [CNT_W-1:0]      target_cycle,
    output logic                  init_done
);

    localparam int TIDW      = NTHREADIDMSB + 1;
    localparam int LAT_LIMIT = 2**STALL_W - 1;

    if (LAT_ALU > LAT_LIMIT || LAT_MUL > LAT_LIMIT || LAT_DIV > LAT_LIMIT || LAT_LDST > LAT_LIMIT) begin : g_lat_check
        $error("tm_cpu_timing_ctrl: a LAT_* parameter does not fit the stall counter");
    end

    tm_ctrl_state_type   state;
    logic [NTHREAD-1:0]  running;
    logic [TIDW-1:0]     clr_tid;
    logic                tok_valid;
    logic                tok_run;
    logic [TIDW-1:0]     tok_tid;

    tm_thread_state_type stall_ram  [NTHREAD];
    logic [CNT_W-1:0]    retire_ram [NTHREAD];

    tm_inst_class_type   inst_class;
    logic [STALL_W-1:0]  cur_stall;
    logic [CNT_W-1:0]    cur_retire;
    logic                tok_live, grant, stalled, do_retire;
    logic                st_we, rt_we;
    logic [TIDW-1:0]     waddr;
    logic [STALL_W-1:0]  wstall;
    logic [CNT_W-1:0]    wretire;
    logic [NTHREAD-1:0]  act_mask, sel_mask;

    tm_inst_classify u_classify (
        .inst       (fm_tok.inst),
        .inst_class (inst_class)
    );

    function automatic logic [STALL_W-1:0] lat_of(input tm_inst_class_type c);
        case (c)
            tm_MUL:  return STALL_W'(LAT_MUL);
            tm_DIV:  return STALL_W'(LAT_DIV);
            tm_LDST: return STALL_W'(LAT_LDST);
            default: return STALL_W'(LAT_ALU);
        endcase
    endfunction

    // Asynchronous RAM read: a write on the previous edge is already visible, so
    // back-to-back tokens for one tid never see a stale stall or retire value.
    assign cur_stall  = stall_ram[fm_tok.tid].stall;
    assign cur_retire = retire_ram[fm_tok.tid];
    assign tok_live   = fm_tok.valid && (state != tm_CLEAR);
    assign grant      = tok_live && running[fm_tok.tid] && (cur_stall == '0);
    assign stalled    = tok_live && running[fm_tok.tid] && (cur_stall != '0);
    assign do_retire  = grant && fm_tok.retired && !fm_tok.replay;

    always_comb begin
        st_we   = 1'b0;
        rt_we   = 1'b0;
        waddr   = fm_tok.tid;
        wstall  = cur_stall;
        wretire = cur_retire;
        if (state == tm_CLEAR) begin
            st_we   = 1'b1;
            rt_we   = 1'b1;
            waddr   = clr_tid;
            wstall  = '0;
            wretire = '0;
        end else if (stalled) begin
            st_we  = 1'b1;
            wstall = cur_stall - STALL_W'(1);
        end else if (do_retire) begin
            st_we   = 1'b1;
            rt_we   = 1'b1;
            wstall  = lat_of(inst_class);
            wretire = cur_retire + CNT_W'(1);
        end
    end

    always_ff @(posedge gclk) begin
        if (st_we) stall_ram[waddr] <= '{stall: wstall};
        if (rt_we) retire_ram[waddr] <= wretire;
    end

    always_comb begin
        act_mask = '0;
        for (int i = 0; i < NTHREAD; i++) begin
            act_mask[i] = (TIDW'(i) <= dma_ctrl.threads_active);
        end
    end

    assign sel_mask = NTHREAD'(1) << dma_ctrl.threads_active;

    always_ff @(posedge gclk) begin
        if (rst) begin
            state        <= tm_CLEAR;
            clr_tid      <= '0;
            running      <= '0;
            init_done    <= 1'b0;
            tok_valid    <= 1'b0;
            tok_run      <= 1'b0;
            tok_tid      <= '0;
            cnt_rd_data  <= '0;
            target_cycle <= '0;
        end else begin
            tok_valid   <= tok_live;
            tok_run     <= grant;
            tok_tid     <= fm_tok.tid;
            cnt_rd_data <= (state == tm_CLEAR) ? '0 : retire_ram[cnt_rd_tid];
            if (state == tm_RUN && fm_tok.valid && fm_tok.tid == dma_ctrl.threads_total) begin
                target_cycle <= target_cycle + CNT_W'(1);
            end
            case (state)
                tm_CLEAR: begin
                    clr_tid <= clr_tid + TIDW'(1);
                    if (clr_tid == TIDW'(NTHREAD - 1)) begin
                        state     <= tm_IDLE;
                        init_done <= 1'b1;
                    end
                end
                tm_IDLE: begin
                    if (dma_ctrl.tm_dbg_ctrl == tm_dbg_start) begin
                        running <= running | act_mask;
                        state   <= tm_RUN;
                    end else if (dma_ctrl.tm_dbg_ctrl == tm_dbg_select_start) begin
                        running <= running | sel_mask;
                        state   <= tm_RUN;
                    end
                end
                tm_RUN: begin
                    if (dma_ctrl.tm_dbg_ctrl == tm_dbg_stop) begin
                        running <= '0;
                        state   <= tm_IDLE;
                    end else if (dma_ctrl.tm_dbg_ctrl == tm_dbg_select_stop) begin
                        running <= running & ~sel_mask;
                        if ((running & ~sel_mask) == '0) state <= tm_IDLE;
                    end
                end
                default: state <= tm_CLEAR;
            endcase
        end
    end

    assign tm_tok = '{valid: tok_valid, run: tok_run, tid: tok_tid, running: (state == tm_RUN)};

endmodule

// File: tb/tb_tm_cpu_timing_ctrl.sv
// tb/tb_tm_cpu_timing_ctrl.sv - self-checking bench for tm_cpu_timing_ctrl
module tb_tm_cpu_timing_ctrl;
    import tm_cpu_timing_ctrl_pkg::*;

    localparam int LA = 0, LM = 3, LD = 11, LL = 1;
    localparam logic [31:0] I_ALU  = 32'h8200_0000;
    localparam logic [31:0] I_UMUL = 32'h9050_4003;
    localparam logic [31:0] I_LD   = 32'hC000_0000;

    logic                  gclk = 1'b0;
    logic                  rst  = 1'b1;
    tm_cpu_ctrl_token_type fm_tok;
    dma_tm_ctrl_type       dma_ctrl;
    tm2cpu_token_type      tm_tok;
    logic [NTHREADIDMSB:0] cnt_rd_tid;
    logic [CNT_W-1:0]      cnt_rd_data;
    logic [CNT_W-1:0]      target_cycle;
    logic                  init_done;

    tm_cpu_timing_ctrl #(.LAT_ALU(LA), .LAT_MUL(LM), .LAT_DIV(LD), .LAT_LDST(LL)) dut (
        .gclk         (gclk),
        .rst          (rst),
        .fm_tok       (fm_tok),
        .dma_ctrl     (dma_ctrl),
        .tm_tok       (tm_tok),
        .cnt_rd_tid   (cnt_rd_tid),
        .cnt_rd_data  (cnt_rd_data),
        .target_cycle (target_cycle),
        .init_done    (init_done)
    );

    always #5 gclk = ~gclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = clearing, 1 = idle, 2 = running
    int          m_state;
    int          m_clr;
    bit          m_init;
    bit          m_run    [NTHREAD];
    int          m_stall  [NTHREAD];
    logic [31:0] m_retire [NTHREAD];
    logic [31:0] m_target;

    logic [31:0] insts [8] = '{32'h8200_0000, 32'h9050_4003, 32'h9058_0000, 32'h90D0_0000,
                               32'h9078_0000, 32'h90F0_0000, 32'hC000_0000, 32'h1000_0000};

    typedef struct {
        tm_dbg_ctrl_type dbg;
        int              act;
        int              tot;
        logic            v;
        int              tid;
        logic            ret;
        logic            rep;
        logic [31:0]     inst;
        int              rd;
        int              exp_run;
        int              exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [31:0] inst);
        logic [1:0] op;
        logic [5:0] op3;
        op  = inst[31:30];
        op3 = inst[24:19];
        if (op == 2'b11) return LL;
        if (op == 2'b10 && op3 inside {6'h0A, 6'h0B, 6'h1A, 6'h1B}) return LM;
        if (op == 2'b10 && op3 inside {6'h0E, 6'h0F, 6'h1E, 6'h1F}) return LD;
        return LA;
    endfunction

    task automatic step(input logic r, input tm_dbg_ctrl_type dbg, input int act, input int tot,
                        input logic v, input int tid, input logic ret, input logic rep,
                        input logic [31:0] inst, input int rd);
        bit          e_valid, e_run, anyrun;
        int          e_tid;
        logic [31:0] e_cnt;
        rst                     = r;
        fm_tok.valid            = v;
        fm_tok.tid              = (NTHREADIDMSB+1)'(tid);
        fm_tok.retired          = ret;
        fm_tok.replay           = rep;
        fm_tok.inst             = inst;
        dma_ctrl.tm_dbg_ctrl    = dbg;
        dma_ctrl.threads_active = (NTHREADIDMSB+1)'(act);
        dma_ctrl.threads_total  = (NTHREADIDMSB+1)'(tot);
        cnt_rd_tid              = (NTHREADIDMSB+1)'(rd);
        if (r) begin
            m_state = 0; m_clr = 0; m_init = 0; m_target = 0;
            for (int i = 0; i < NTHREAD; i++) begin
                m_run[i] = 0; m_stall[i] = 0; m_retire[i] = 0;
            end
            e_valid = 0; e_run = 0; e_tid = 0; e_cnt = 0;
        end else begin
            e_valid = v && (m_state != 0);
            e_run   = e_valid && m_run[tid] && (m_stall[tid] == 0);
            e_tid   = tid;
            e_cnt   = (m_state == 0) ? 32'd0 : m_retire[rd];
            if (e_valid && m_run[tid] && m_stall[tid] > 0) begin
                m_stall[tid]--;
            end else if (e_run && ret && !rep) begin
                m_stall[tid] = lat_of(inst);
                m_retire[tid]++;
            end
            if (m_state == 2 && v && tid == tot) m_target++;
            case (m_state)
                0: begin
                    m_clr++;
                    if (m_clr == NTHREAD) begin m_state = 1; m_init = 1; end
                end
                1: begin
                    if (dbg == tm_dbg_start) begin
                        for (int i = 0; i <= act; i++) m_run[i] = 1;
                        m_state = 2;
                    end else if (dbg == tm_dbg_select_start) begin
                        m_run[act] = 1;
                        m_state = 2;
                    end
                end
                default: begin
                    if (dbg == tm_dbg_stop) begin
                        for (int i = 0; i < NTHREAD; i++) m_run[i] = 0;
                        m_state = 1;
                    end else if (dbg == tm_dbg_select_stop) begin
                        m_run[act] = 0;
                        anyrun = 0;
                        for (int i = 0; i < NTHREAD; i++) anyrun |= m_run[i];
                        if (!anyrun) m_state = 1;
                    end
                end
            endcase
        end
        @(posedge gclk);
        #1;
        chk("tok_valid", tm_tok.valid, e_valid);
        if (e_valid || r) begin
            chk("tok_run", tm_tok.run, e_run);
            chk("tok_tid", tm_tok.tid, e_tid);
        end
        chk("tok_running", tm_tok.running, m_state == 2);
        chk("cnt_rd_data", cnt_rd_data, e_cnt);
        chk("target_cycle", target_cycle, m_target);
        chk("init_done", init_done, m_init);
    endtask

    task automatic add(input tm_dbg_ctrl_type dbg, input int act, input logic v, input int tid,
                       input logic ret, input logic rep, input logic [31:0] inst, input int rd,
                       input int exp_run, input int exp_cnt);
        vec_t e;
        e.dbg = dbg; e.act = act; e.tot = 63; e.v = v; e.tid = tid; e.ret = ret; e.rep = rep;
        e.inst = inst; e.rd = rd; e.exp_run = exp_run; e.exp_cnt = exp_cnt;
        tbl.push_back(e);
    endtask

    task automatic run_tbl();
        foreach (tbl[k]) begin
            step(1'b0, tbl[k].dbg, tbl[k].act, tbl[k].tot, tbl[k].v, tbl[k].tid, tbl[k].ret,
                 tbl[k].rep, tbl[k].inst, tbl[k].rd);
            if (tbl[k].exp_run >= 0) chk($sformatf("tbl_run[%0d]", k), tm_tok.run, tbl[k].exp_run);
            if (tbl[k].exp_cnt >= 0) chk($sformatf("tbl_cnt[%0d]", k), cnt_rd_data, tbl[k].exp_cnt);
        end
        tbl.delete();
    endtask

    initial begin
        tm_dbg_ctrl_type d;
        int r;

        for (int i = 0; i < 3; i++) step(1'b1, tm_dbg_nop, 0, 63, 1'b0, 0, 1'b0, 1'b0, I_ALU, 0);
        for (int i = 0; i < 30; i++)
            step(1'b0, tm_dbg_start, 3, 63, 1'b1, $urandom_range(0, 63), 1'b1, 1'b0, I_ALU, i);
        step(1'b1, tm_dbg_nop, 0, 63, 1'b0, 0, 1'b0, 1'b0, I_ALU, 0);
        for (int c = 1; c <= 64; c++) begin
            step(1'b0, tm_dbg_nop, 0, 63, 1'b0, 0, 1'b0, 1'b0, I_ALU, c - 1);
            if (c == 63) chk("init_done_early", init_done, 0);
        end
        chk("init_done_at_64", init_done, 1);
        for (int t = 0; t < 8; t++) step(1'b0, tm_dbg_nop, 0, 63, 1'b0, 0, 1'b0, 1'b0, I_ALU, t * 9);

        add(tm_dbg_nop,   3, 1'b1, 3, 1'b1, 1'b0, I_ALU,  0,  0, -1);
        add(tm_dbg_start, 3, 1'b0, 0, 1'b0, 1'b0, I_ALU,  0, -1, -1);
        add(tm_dbg_nop,   3, 1'b1, 0, 1'b1, 1'b0, I_ALU,  0,  1,  0);
        add(tm_dbg_nop,   3, 1'b1, 1, 1'b1, 1'b0, I_ALU,  0,  1,  1);
        add(tm_dbg_nop,   3, 1'b1, 2, 1'b1, 1'b0, I_ALU,  1,  1,  1);
        add(tm_dbg_nop,   3, 1'b1, 3, 1'b1, 1'b0, I_ALU,  2,  1,  1);
        add(tm_dbg_nop,   3, 1'b1, 4, 1'b1, 1'b0, I_ALU,  3,  0,  1);
        add(tm_dbg_nop,   3, 1'b1, 2, 1'b1, 1'b0, I_UMUL, 4,  1,  0);
        add(tm_dbg_nop,   3, 1'b1, 3, 1'b1, 1'b0, I_ALU,  2,  1,  2);
        add(tm_dbg_nop,   3, 1'b1, 2, 1'b1, 1'b0, I_ALU,  2,  0,  2);
        add(tm_dbg_nop,   3, 1'b1, 0, 1'b1, 1'b0, I_ALU,  2,  1,  2);
        add(tm_dbg_nop,   3, 1'b1, 2, 1'b1, 1'b0, I_ALU,  2,  0,  2);
        add(tm_dbg_nop,   3, 1'b1, 2, 1'b1, 1'b0, I_ALU,  2,  0,  2);
        add(tm_dbg_nop,   3, 1'b1, 2, 1'b1, 1'b0, I_ALU,  2,  1,  2);
        add(tm_dbg_nop,   3, 1'b0, 0, 1'b0, 1'b0, I_ALU,  2, -1,  3);
        run_tbl();

        for (int round = 0; round < 3; round++)
            for (int t = 0; t < 8; t++)
                step(1'b0, tm_dbg_nop, 3, 7, 1'b1, t, 1'b0, 1'b0, I_ALU, t);
        chk("target_after_3_rounds", target_cycle, 3);
        step(1'b0, tm_dbg_stop, 3, 7, 1'b0, 0, 1'b0, 1'b0, I_ALU, 0);
        chk("stop_running", tm_tok.running, 0);
        step(1'b0, tm_dbg_nop, 3, 7, 1'b1, 7, 1'b0, 1'b0, I_ALU, 0);
        chk("target_hold_idle", target_cycle, 3);

        add(tm_dbg_select_start, 5, 1'b0, 0, 1'b0, 1'b0, I_ALU, 5, -1, -1);
        add(tm_dbg_nop,          5, 1'b1, 5, 1'b1, 1'b0, I_ALU, 5,  1,  0);
        add(tm_dbg_nop,          5, 1'b1, 5, 1'b1, 1'b0, I_ALU, 5,  1,  1);
        add(tm_dbg_nop,          5, 1'b1, 5, 1'b1, 1'b0, I_LD,  5,  1,  2);
        add(tm_dbg_nop,          5, 1'b1, 5, 1'b1, 1'b0, I_LD,  5,  0,  3);
        add(tm_dbg_nop,          5, 1'b1, 5, 1'b1, 1'b0, I_LD,  5,  1,  3);
        add(tm_dbg_nop,          5, 1'b0, 0, 1'b0, 1'b0, I_ALU, 5, -1,  4);
        add(tm_dbg_stop,         5, 1'b0, 0, 1'b0, 1'b0, I_ALU, 9, -1,  0);
        add(tm_dbg_select_start, 9, 1'b0, 0, 1'b0, 1'b0, I_ALU, 9, -1, -1);
        for (int k = 0; k < 5; k++) add(tm_dbg_nop, 9, 1'b1, 9, 1'b1, 1'b1, I_ALU, 9, 1, 0);
        add(tm_dbg_select_stop,  9, 1'b0, 0, 1'b0, 1'b0, I_ALU, 9, -1,  0);
        run_tbl();
        chk("select_stop_idle", tm_tok.running, 0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0:       d = tm_dbg_start;
                1:       d = tm_dbg_stop;
                2:       d = tm_dbg_select_start;
                3:       d = tm_dbg_select_stop;
                default: d = tm_dbg_nop;
            endcase
            step(1'b0, d, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 1) != 0) ? insts[$urandom_range(0, 7)] : 32'($urandom),
                 $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
